// File: rtl/dbg_bus_bridge.sv
// rtl/dbg_bus_bridge.sv - UART debug frame to memory bus bridge
module dbg_bus_bridge #(
    parameter int BUS_TIMEOUT   = 255,
    parameter int FRAME_TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy,
    output logic        overrun
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_BUS  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_TMO  = 8'h54;

    localparam int BW = $clog2(BUS_TIMEOUT + 1);
    localparam int FW = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [BW-1:0] BUS_LAST   = BW'(BUS_TIMEOUT - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TIMEOUT - 1);

    logic [2:0]    state;
    logic          is_write;
    logic [1:0]    byte_cnt;
    logic [FW-1:0] frame_cnt;
    logic [BW-1:0] bus_cnt;
    logic [31:0]   rdata_q;
    logic [2:0]    tx_left;
    logic          frame_expire;
    logic          in_frame;

    assign busy         = (state != S_IDLE);
    assign in_frame     = (state == S_ADDR) || (state == S_DATA);
    // The FRAME_TIMEOUT-th idle cycle expires the frame, even if a byte lands in it.
    assign frame_expire = in_frame && (frame_cnt == FRAME_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            is_write    <= 1'b0;
            byte_cnt    <= 2'd0;
            frame_cnt   <= '0;
            bus_cnt     <= '0;
            rdata_q     <= 32'h0;
            tx_left     <= 3'd0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            mem_valid_o <= 1'b0;
            mem_addr_o  <= 32'h0;
            mem_wdata_o <= 32'h0;
            mem_wstrb_o <= 4'h0;
            overrun     <= 1'b0;
        end else begin
            if (rx_valid && (state == S_BUS || state == S_RESP)) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (rx_valid && (rx_data == OP_WRITE || rx_data == OP_READ)) begin
                        is_write  <= (rx_data == OP_WRITE);
                        byte_cnt  <= 2'd0;
                        frame_cnt <= '0;
                        state     <= S_ADDR;
                    end
                end
                S_ADDR, S_DATA: begin
                    if (frame_expire) begin
                        state <= S_IDLE;
                    end else if (rx_valid) begin
                        frame_cnt <= '0;
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (state == S_ADDR) begin
                            mem_addr_o <= {mem_addr_o[23:0], rx_data};
                        end else begin
                            mem_wdata_o <= {mem_wdata_o[23:0], rx_data};
                        end
                        if (byte_cnt == 2'd3) begin
                            if (state == S_ADDR && is_write) begin
                                state <= S_DATA;
                            end else begin
                                state       <= S_BUS;
                                mem_valid_o <= 1'b1;
                                mem_wstrb_o <= is_write ? 4'hF : 4'h0;
                                bus_cnt     <= '0;
                            end
                        end
                    end else if (frame_cnt < FRAME_LAST) begin
                        frame_cnt <= frame_cnt + FW'(1);
                    end
                end
                S_BUS: begin
                    if (mem_ready_i) begin
                        mem_valid_o <= 1'b0;
                        rdata_q     <= mem_rdata_i;
                        tx_data     <= RSP_OK;
                        tx_valid    <= 1'b1;
                        tx_left     <= is_write ? 3'd0 : 3'd4;
                        state       <= S_RESP;
                    end else if (bus_cnt == BUS_LAST) begin
                        mem_valid_o <= 1'b0;
                        tx_data     <= RSP_TMO;
                        tx_valid    <= 1'b1;
                        tx_left     <= 3'd0;
                        state       <= S_RESP;
                    end else begin
                        bus_cnt <= bus_cnt + BW'(1);
                    end
                end
                S_RESP: begin
                    // Read data is streamed MSB first by shifting the captured word.
                    if (tx_valid && tx_ready) begin
                        if (tx_left == 3'd0) begin
                            tx_valid <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            tx_data <= rdata_q[31:24];
                            rdata_q <= {rdata_q[23:0], 8'h00};
                            tx_left <= tx_left - 3'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbg_bus_bridge.sv
// tb/tb_dbg_bus_bridge.sv - self-checking bench for dbg_bus_bridge
module tb_dbg_bus_bridge;
    localparam int BUS_TIMEOUT   = 8;
    localparam int FRAME_TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_rdata_i;
    logic        busy;
    logic        overrun;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          ok;
        int          cycles;
    } bus_rec_t;

    bus_rec_t    bus_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] bus_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    int          resp_delay = 0;
    bit          no_resp = 1'b0;
    int          valid_viol = 0;
    int          unstable = 0;
    int          checks = 0;
    int          failures = 0;

    dbg_bus_bridge #(.BUS_TIMEOUT(BUS_TIMEOUT), .FRAME_TIMEOUT(FRAME_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_rdata_i(mem_rdata_i),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a == 32'h0000_1004) ? 32'h0000_012C : (a ^ 32'h5A5A_1234);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Responder, bus monitor and tx monitor: sample at negedge, drive just after posedge.
    initial begin : bus_side
        logic        hs;
        logic        prev_valid;
        logic [31:0] a0;
        logic [31:0] w0;
        logic [3:0]  s0;
        int          cyc;
        int          wait_cnt;
        hs = 1'b0; prev_valid = 1'b0; a0 = '0; w0 = '0; s0 = '0; cyc = 0; wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
            if (mem_valid_o) begin
                if (hs) valid_viol++;
                if (!prev_valid) begin
                    a0 = mem_addr_o; w0 = mem_wdata_o; s0 = mem_wstrb_o; cyc = 0;
                end
                cyc++;
                if (mem_addr_o !== a0 || mem_wdata_o !== w0 || mem_wstrb_o !== s0) unstable++;
                if (mem_ready_i) begin
                    bus_q.push_back('{a0, w0, s0, 1'b1, cyc});
                    if (s0 == 4'hF) bus_mem[a0] = w0;
                end
            end else if (prev_valid && !hs) begin
                bus_q.push_back('{a0, w0, s0, 1'b0, cyc});
            end
            hs = mem_valid_o && mem_ready_i;
            prev_valid = mem_valid_o;
            @(posedge clk);
            #1;
            if (hs || !mem_valid_o || no_resp) begin
                mem_ready_i = 1'b0;
                wait_cnt = 0;
            end else if (wait_cnt >= resp_delay) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = bus_mem.exists(mem_addr_o) ? bus_mem[mem_addr_o] : init_word(mem_addr_o);
            end else begin
                mem_ready_i = 1'b0;
                wait_cnt++;
            end
        end
    end

    // mode 0: tx_ready always high, 1: random, 2: stall 3 cycles on the second byte
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input int delay, input bit nr, input int mode, input bit inj);
        logic [7:0]  frame[$];
        logic [7:0]  exp_tx[$];
        logic [31:0] word;
        logic [7:0]  got;
        int          stall;
        frame.push_back(wr ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) frame.push_back(addr[i*8 +: 8]);
        if (wr) for (int i = 3; i >= 0; i--) frame.push_back(data[i*8 +: 8]);
        resp_delay = delay;
        no_resp = nr;
        bus_q.delete();
        tx_q.delete();
        stall = 0;
        for (int i = 0; i < frame.size(); i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            if (i == frame.size() - 1) check("valid_before_last", mem_valid_o, 0);
            send_byte(frame[i]);
            if (i != frame.size() - 1) idle($urandom_range(0, 2));
        end
        check("valid_latency", mem_valid_o, 1);
        if (inj) begin
            send_byte(8'h52);
            check("overrun_set", overrun, 1);
        end
        for (int c = 0; c < 300; c++) begin
            if (!busy) break;
            if (mode == 0) tx_ready = 1'b1;
            else if (mode == 1) tx_ready = 1'($urandom_range(0, 1));
            else if (tx_valid && tx_q.size() == 1 && stall < 3) begin
                tx_ready = 1'b0;
                stall++;
            end else tx_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        check("txn_done", busy, 0);

        if (nr) exp_tx.push_back(8'h54);
        else begin
            exp_tx.push_back(8'h4B);
            if (wr) ref_mem[addr] = data;
            else begin
                word = ref_mem.exists(addr) ? ref_mem[addr] : init_word(addr);
                for (int i = 3; i >= 0; i--) exp_tx.push_back(word[i*8 +: 8]);
            end
        end
        check("bus_count", bus_q.size(), 1);
        if (bus_q.size() > 0) begin
            check("bus_addr", bus_q[0].addr, addr);
            check("bus_wstrb", bus_q[0].wstrb, wr ? 4'hF : 4'h0);
            check("bus_ok", bus_q[0].ok, !nr);
            check("bus_cycles", bus_q[0].cycles, nr ? BUS_TIMEOUT : delay + 1);
            if (wr) check("bus_wdata", bus_q[0].wdata, data);
        end
        check("tx_count", tx_q.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size(); i++) begin
            got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            check($sformatf("tx_byte%0d", i), got, exp_tx[i]);
        end
        idle(2);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
        mem_ready_i = 1'b0; mem_rdata_i = 32'h0;
        idle(3);
        check("rst_busy", busy, 0);
        check("rst_valid", mem_valid_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_wstrb", mem_wstrb_o, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        idle(2);

        run_txn(1'b1, 32'h0000_1000, 32'h0000_01F4, 2, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h0000_1004, 32'h0, 1, 1'b0, 2, 1'b0);
        run_txn(1'b0, 32'hDEAD_0000, 32'h0, 0, 1'b1, 0, 1'b0);

        // Truncated frame must expire after exactly FRAME_TIMEOUT idle cycles.
        bus_q.delete(); tx_q.delete();
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("frame_timeout_cycles", n, FRAME_TIMEOUT);
        idle(3);
        check("frame_timeout_no_bus", bus_q.size(), 0);
        check("frame_timeout_no_tx", tx_q.size(), 0);

        // A byte arriving on the expiry cycle is discarded.
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
        idle(FRAME_TIMEOUT - 1);
        send_byte(8'h10);
        check("expiry_beats_byte", busy, 0);
        idle(FRAME_TIMEOUT + 5);
        check("expiry_no_bus", bus_q.size(), 0);

        send_byte(8'h41);
        check("junk_ignored_busy", busy, 0);
        check("junk_no_overrun", overrun, 0);
        run_txn(1'b0, 32'h0000_1000, 32'h0, 4, 1'b0, 0, 1'b1);

        // Reset while the bus request is outstanding.
        bus_q.delete(); tx_q.delete();
        no_resp = 1'b1;
        send_byte(8'h52); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        idle(3);
        check("pre_rst_valid", mem_valid_o, 1);
        rst = 1'b1;
        idle(1);
        check("mid_rst_valid", mem_valid_o, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_overrun", overrun, 0);
        rst = 1'b0;
        idle(BUS_TIMEOUT + 4);
        check("post_rst_no_tx", tx_q.size(), 0);
        check("post_rst_idle", busy, 0);
        run_txn(1'b1, 32'h0000_2000, 32'hCAFE_F00D, 0, 1'b0, 1, 1'b0);

        for (int k = 0; k < 12; k++) begin
            run_txn(1'($urandom_range(0, 1)), 32'h0000_2000 + 32'($urandom_range(0, 3) * 4),
                    $urandom, $urandom_range(0, 5), ($urandom_range(0, 5) == 0),
                    $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
        end

        check("valid_gap_after_accept", valid_viol, 0);
        check("bus_fields_stable", unstable, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dbg_bus_bridge.md
DBG_BUS_BRIDGE -- requirements
Module: dbg_bus_bridge

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 255, max cycles mem_valid_o held awaiting mem_ready_i.
REQ-002 SHALL have parameter FRAME_TIMEOUT, default 100000, max idle cycles between bytes of one frame.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk, rst.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 rx_data  input  8  received byte from UART receiver.
REQ-007 rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-008 tx_data  output  8  response byte to UART transmitter.
REQ-009 tx_valid  output  1  tx_data valid; held until tx_ready.
REQ-010 tx_ready  input  1  transmitter accepts byte when tx_valid && tx_ready.
REQ-011 mem_valid_o  output  1  bus request (initiator side of mem bus).
REQ-012 mem_ready_i  input  1  responder acknowledge.
REQ-013 mem_addr_o  output  32  byte address.
REQ-014 mem_wdata_o  output  32  write data.
REQ-015 mem_wstrb_o  output  4  byte strobes; 4'hF write, 4'h0 read.
REQ-016 mem_rdata_i  input  32  read data, valid in mem_ready_i cycle.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 overrun  output  1  sticky: byte received while in BUS or RESP.

Function
REQ-019 Frames: write = 0x57, addr[31:24..7:0], data[31:24..7:0] (9 bytes); read = 0x52, addr MSB first (5 bytes).
REQ-020 States: IDLE, ADDR, DATA, BUS, RESP.
REQ-021 IDLE: rx_valid with 0x57/0x52 -> ADDR, latch opcode, byte count 0; any other byte discarded, stay IDLE.
REQ-022 ADDR: each rx_valid shifts byte into addr LSB side; after 4th byte -> DATA (write) or BUS (read).
REQ-023 DATA: same shifting into wdata; after 4th byte -> BUS.
REQ-024 BUS entry: mem_valid_o=1 next cycle; addr/wdata/wstrb stable while mem_valid_o high.
REQ-025 BUS: first cycle with mem_valid_o && mem_ready_i captures mem_rdata_i, status OK; mem_valid_o=0 next cycle; -> RESP.
REQ-026 Bus timeout counter counts cycles with mem_valid_o high; on reaching BUS_TIMEOUT with no ready, mem_valid_o=0 next cycle, status TIMEOUT, -> RESP.
REQ-027 mem_valid_o SHALL never be re-asserted in the cycle immediately after deassertion (responder needs one idle cycle).
REQ-028 RESP: OK write sends 0x4B; OK read sends 0x4B then rdata MSB first (5 bytes); TIMEOUT sends 0x54 only.
REQ-029 Each response byte presented on tx_data with tx_valid=1 until accepted; next byte presented cycle after acceptance; after last accepted -> IDLE.
REQ-030 tx_ready while tx_valid=0 SHALL have no effect.
REQ-031 Frame timer in ADDR/DATA: reset on each rx_valid; reaching FRAME_TIMEOUT -> IDLE, partial frame discarded, no bus access, no response.
REQ-032 rx_valid in BUS/RESP: byte dropped, overrun set 1; cleared only by rst.
REQ-033 rx_valid coinciding with frame timeout expiry: timeout wins, byte discarded.
REQ-034 Timeout counters SHALL saturate, not wrap; widths sized via $clog2 of parameters.
REQ-035 Latency: mem_valid_o rises exactly 1 cycle after final frame byte's rx_valid.

Reset
REQ-036 rst SHALL force IDLE, mem_valid_o=0, mem_addr_o=0, mem_wdata_o=0, mem_wstrb_o=0, tx_valid=0, tx_data=0, busy=0, overrun=0, counters 0.
REQ-037 rst mid-transaction SHALL drop mem_valid_o and tx_valid the following cycle; no response byte emitted afterwards.

Verification
REQ-038 Write 0x57,00,00,10,00,00,00,01,F4, responder ready after 2 cycles -> one bus write addr 0x00001000 wdata 0x000001F4 wstrb F, then tx 0x4B.
REQ-039 Read 0x52,00,00,10,04, responder returns 0x0000012C -> wstrb 0, tx 0x4B,00,00,01,2C in order, with tx_ready stalled 3 cycles on byte 2.
REQ-040 Read to non-responding address, BUS_TIMEOUT=8 -> mem_valid_o high exactly 8 cycles, tx 0x54 only, then IDLE.
REQ-041 0x57 + 3 addr bytes then silence, FRAME_TIMEOUT=20 -> IDLE after 20 cycles, no mem_valid_o, no tx.
REQ-042 Byte 0x41 in IDLE -> ignored; byte during BUS -> overrun=1, transaction result unchanged.
REQ-043 rst asserted while mem_valid_o high -> mem_valid_o=0, busy=0 next cycle; subsequent valid frame processed normally.
